// File: rtl/scan_index_gen.sv
// scan_index_gen: dwell-timed 3-bit index scanner driving a 3-to-8 decoder
module scan_index_gen #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               dir,
    input  logic               cont,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         sel,
    output logic               en,
    output logic               busy,
    output logic               done
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state_q, state_d;
    logic [2:0] sel_q, sel_d, pos_q, pos_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d, dwell_q, dwell_d;
    logic dir_q, dir_d, cont_q, cont_d;
    logic last;
    assign last = (cnt_q == '0) && (pos_q == 3'd7);
    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            pos_q   <= '0;
            cnt_q   <= '0;
            dwell_q <= '0;
            dir_q   <= 1'b0;
            cont_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            dir_q   <= dir_d;
            cont_q  <= cont_d;
        end
    end
    // next state: stop wins over advance and pass completion
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? SCAN : IDLE;
            SCAN:    state_d = stop ? IDLE : (last && !cont_q) ? DONE : SCAN;
            default: state_d = IDLE;
        endcase
    end
    // datapath: latch settings at start, count down dwell, step index at zero
    always_comb begin
        sel_d   = sel_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        dir_d   = dir_q;
        cont_d  = cont_q;
        if (state_q == IDLE && start) begin
            sel_d   = dir ? 3'd7 : 3'd0;
            pos_d   = '0;
            cnt_d   = dwell;
            dwell_d = dwell;
            dir_d   = dir;
            cont_d  = cont;
        end else if (state_q == SCAN && !stop) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else if (!(last && !cont_q)) begin
                sel_d = dir_q ? sel_q - 3'd1 : sel_q + 3'd1;
                pos_d = pos_q + 3'd1;
                cnt_d = dwell_q;
            end
        end
    end
    // outputs come straight from registers
    always_comb begin
        sel  = sel_q;
        en   = state_q == SCAN;
        busy = state_q == SCAN;
        done = state_q == DONE;
    end
endmodule

// File: tb/tb_scan_index_gen.sv
// tb_scan_index_gen: directed and random checks against a cycle-count reference model
module tb_scan_index_gen;
    localparam int DW = 4;
    logic clk = 1'b0;
    logic rst, start, stop, dir, cont;
    logic [DW-1:0] dwell;
    logic [2:0] sel;
    logic en, busy, done;
    int checks = 0;
    int errors = 0;
    // model: 0 idle, 1 scan, 2 done; index derived from cycles since start
    int m_mode = 0;
    int m_sel = 0;
    int m_k = 0;
    int m_d = 0;
    bit m_dir = 0;
    bit m_cont = 0;

    scan_index_gen #(.DWELL_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir),
        .cont(cont), .dwell(dwell), .sel(sel), .en(en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int idx_at(input int k);
        int i;
        i = (k / (m_d + 1)) % 8;
        return m_dir ? 7 - i : i;
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst) begin
            m_mode = 0;
            m_sel = 0;
        end else if (m_mode == 0) begin
            if (start) begin
                m_mode = 1;
                m_dir = dir;
                m_cont = cont;
                m_d = int'(dwell);
                m_k = 0;
                m_sel = idx_at(0);
            end
        end else if (m_mode == 1) begin
            if (stop) m_mode = 0;
            else begin
                m_k++;
                if (!m_cont && m_k == 8 * (m_d + 1)) m_mode = 2;
                else m_sel = idx_at(m_k);
            end
        end else m_mode = 0;
        #1;
        chk("sel", int'(sel), m_sel);
        chk("en", int'(en), int'(m_mode == 1));
        chk("busy", int'(busy), int'(m_mode == 1));
        chk("done", int'(done), int'(m_mode == 2));
    endtask

    task automatic go(input bit d, input bit c, input int dw);
        dir = d; cont = c; dwell = DW'(dw); start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0; cont = 1'b0; dwell = '0;
        #1;
        step();
        step();
        rst = 1'b0;
        chk("rst_sel", int'(sel), 0);
        step();
        step();
        chk("idle_wait", int'(busy), 0);
        // single ascending pass, no dwell: one-hot walk
        go(0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            chk("walk", int'(sel), i);
            chk("onehot", int'(8'(1) << sel), int'(8'(1) << i));
            if (i < 7) step();
        end
        step();
        chk("pass_done", int'(done), 1);
        chk("pass_sel", int'(sel), 7);
        step();
        chk("back_idle", int'(en), 0);
        // descending, dwell=2: 24 enable cycles, settings change mid-scan
        go(1, 0, 2);
        begin
            int n = 1;
            dir = 1'b0; dwell = 4'd9;
            while (en && n < 100) begin step(); if (en) n++; end
            chk("desc_len", n, 24);
        end
        chk("desc_done", int'(done), 1);
        step();
        // continuous, 20 cycles, start pulses ignored mid-scan
        go(0, 1, 0);
        for (int i = 1; i < 20; i++) begin
            start = (i % 5 == 0);
            step();
        end
        start = 1'b0;
        chk("cont_sel", int'(sel), 3);
        // stop mid-dwell at sel 4 with dwell 3
        stop = 1'b1;
        step();
        stop = 1'b0;
        go(0, 0, 3);
        for (int i = 0; i < 17; i++) step();
        chk("mid4", int'(sel), 4);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_en", int'(en), 0);
        go(0, 0, 3);
        chk("restart", int'(sel), 0);
        // reset at sel 5, and during DONE
        for (int i = 0; i < 20; i++) step();
        chk("at5", int'(sel), 5);
        rst = 1'b1; start = 1'b1;
        step();
        rst = 1'b0; start = 1'b0;
        chk("rst_scan", int'(sel), 0);
        go(1, 0, 0);
        for (int i = 0; i < 8; i++) step();
        chk("in_done", int'(done), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_done", int'(done), 0);
        // boundary: dwell all-ones holds each index 16 cycles
        go(0, 0, (1 << DW) - 1);
        for (int i = 0; i < 16; i++) step();
        chk("max_dwell", int'(sel), 1);
        for (int i = 0; i < 8 * 16; i++) step();
        // random traffic
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 24) == 0);
            dir = 1'($urandom);
            cont = 1'($urandom);
            dwell = DW'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 2));
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
